// File: rtl/axi4_m_rd_mo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi4_m_rd_mo: queued multi-outstanding AXI4 read master with per-ID completion |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi4_m_rd_mo #(
    parameter int TAGW = 3,
    parameter int ADRW = 32,
    parameter int DATW = 256,
    parameter int MAXO = 4,
    parameter int QDEP = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [ADRW-1:0] req_addr,
    input  logic [7:0]      req_len,
    input  logic [2:0]      req_size,
    input  logic            req_valid,
    output logic            req_ready,
    output logic [TAGW-1:0] o_m_arid,
    output logic [ADRW-1:0] o_m_araddr,
    output logic [7:0]      o_m_arlen,
    output logic [2:0]      o_m_arsize,
    output logic [1:0]      o_m_arburst,
    output logic            o_m_arlock,
    output logic [3:0]      o_m_arcache,
    output logic [2:0]      o_m_arprot,
    output logic [3:0]      o_m_arregion,
    output logic            o_m_arvalid,
    input  logic            i_m_arready,
    input  logic [TAGW-1:0] i_m_rid,
    input  logic [DATW-1:0] i_m_rdata,
    input  logic [1:0]      i_m_rresp,
    input  logic            i_m_rlast,
    input  logic            i_m_rvalid,
    output logic            o_m_rready,
    output logic [TAGW-1:0] o_rsp_id,
    output logic [DATW-1:0] o_rsp_data,
    output logic            o_rsp_last,
    output logic [1:0]      o_rsp_resp,
    output logic            o_rsp_valid,
    input  logic            i_rsp_ready,
    output logic            o_cpl_valid,
    output logic [TAGW-1:0] o_cpl_id,
    output logic [1:0]      o_cpl_resp,
    output logic [8:0]      o_cpl_beats,
    output logic            o_cpl_lenerr,
    output logic            o_stray
);

    localparam int QAW = $clog2(QDEP);
    localparam logic [QAW:0] Q_FULL = (QAW+1)'(QDEP);
    localparam logic [QAW:0] Q_ONE  = (QAW+1)'(1);
    localparam logic [QAW:0] Q_TWO  = (QAW+1)'(2);
    localparam logic [8:0]   CNT_SAT = 9'd256;

    // Returns {found, index} of the lowest clear bit.
    function automatic logic [TAGW:0] find_free(input logic [MAXO-1:0] b);
        logic [TAGW:0] r;
        r = '0;
        for (int i = MAXO - 1; i >= 0; i--) begin
            if (!b[i]) r = {1'b1, TAGW'(i)};
        end
        return r;
    endfunction

    logic [ADRW-1:0] q_addr [QDEP];
    logic [7:0]      q_len  [QDEP];
    logic [2:0]      q_size [QDEP];
    logic [QAW-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [QAW:0]    q_count;

    logic [MAXO-1:0] busy;
    logic [8:0]      cnt     [MAXO];
    logic [7:0]      exp_len [MAXO];
    logic [1:0]      worst   [MAXO];

    logic            push, ar_hs, beat;
    logic [MAXO-1:0] arid_mask, rid_mask;
    logic            rid_busy;
    logic [8:0]      cur_cnt, new_cnt;
    logic [7:0]      cur_exp;
    logic [1:0]      cur_worst, new_worst, rresp_norm;
    logic [TAGW:0]   free0, free1;
    logic            start_issue, chain_issue;
    logic [ADRW-1:0] hd_addr, nx_addr;
    logic [7:0]      hd_len, nx_len;
    logic [2:0]      hd_size, nx_size;

    assign req_ready    = (q_count != Q_FULL);
    assign o_m_rready   = !o_rsp_valid || i_rsp_ready;
    assign push         = req_valid && req_ready;
    assign ar_hs        = o_m_arvalid && i_m_arready;
    assign beat         = i_m_rvalid && o_m_rready;
    assign rd_next      = rd_ptr + 1'b1;

    assign o_m_arburst  = 2'b01;
    assign o_m_arlock   = 1'b0;
    assign o_m_arcache  = 4'b0011;
    assign o_m_arprot   = 3'b000;
    assign o_m_arregion = 4'b0000;

    always_comb begin
        arid_mask = '0;
        rid_mask  = '0;
        cur_cnt   = '0;
        cur_exp   = '0;
        cur_worst = '0;
        for (int i = 0; i < MAXO; i++) begin
            arid_mask[i] = (o_m_arid == TAGW'(i));
            rid_mask[i]  = (i_m_rid == TAGW'(i));
            if (i_m_rid == TAGW'(i)) begin
                cur_cnt   = cnt[i];
                cur_exp   = exp_len[i];
                cur_worst = worst[i];
            end
        end
        rid_busy   = |(busy & rid_mask);
        rresp_norm = (i_m_rresp == 2'b01) ? 2'b00 : i_m_rresp;
        new_worst  = (rresp_norm > cur_worst) ? rresp_norm : cur_worst;
        new_cnt    = (cur_cnt == CNT_SAT) ? cur_cnt : cur_cnt + 9'd1;

        // The request being pushed this cycle is bypassed straight into the AR
        // registers when it is the entry that would otherwise be read next.
        free0       = find_free(busy);
        free1       = find_free(busy | arid_mask);
        start_issue = !o_m_arvalid && ((q_count != '0) || push) && free0[TAGW];
        chain_issue = ar_hs && ((q_count >= Q_TWO) || ((q_count == Q_ONE) && push))
                      && free1[TAGW];
        hd_addr = (q_count != '0) ? q_addr[rd_ptr] : req_addr;
        hd_len  = (q_count != '0) ? q_len[rd_ptr]  : req_len;
        hd_size = (q_count != '0) ? q_size[rd_ptr] : req_size;
        nx_addr = (q_count >= Q_TWO) ? q_addr[rd_next] : req_addr;
        nx_len  = (q_count >= Q_TWO) ? q_len[rd_next]  : req_len;
        nx_size = (q_count >= Q_TWO) ? q_size[rd_next] : req_size;
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            q_addr[wr_ptr] <= req_addr;
            q_len[wr_ptr]  <= req_len;
            q_size[wr_ptr] <= req_size;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (ar_hs) rd_ptr <= rd_next;
            if (push && !ar_hs)      q_count <= q_count + Q_ONE;
            else if (!push && ar_hs) q_count <= q_count - Q_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_m_arvalid <= 1'b0;
            o_m_arid    <= '0;
            o_m_araddr  <= '0;
            o_m_arlen   <= '0;
            o_m_arsize  <= '0;
        end else if (chain_issue) begin
            o_m_arid   <= free1[TAGW-1:0];
            o_m_araddr <= nx_addr;
            o_m_arlen  <= nx_len;
            o_m_arsize <= nx_size;
        end else if (ar_hs) begin
            o_m_arvalid <= 1'b0;
        end else if (start_issue) begin
            o_m_arvalid <= 1'b1;
            o_m_arid    <= free0[TAGW-1:0];
            o_m_araddr  <= hd_addr;
            o_m_arlen   <= hd_len;
            o_m_arsize  <= hd_size;
        end
    end

    // The allocator never hands out a busy ID, so AR and R updates cannot collide.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy <= '0;
            for (int i = 0; i < MAXO; i++) begin
                cnt[i]     <= '0;
                exp_len[i] <= '0;
                worst[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < MAXO; i++) begin
                if (ar_hs && arid_mask[i]) begin
                    busy[i]    <= 1'b1;
                    exp_len[i] <= o_m_arlen;
                    cnt[i]     <= '0;
                    worst[i]   <= '0;
                end else if (beat && rid_busy && rid_mask[i]) begin
                    cnt[i]   <= new_cnt;
                    worst[i] <= new_worst;
                    if (i_m_rlast) busy[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_rsp_valid  <= 1'b0;
            o_rsp_id     <= '0;
            o_rsp_data   <= '0;
            o_rsp_last   <= 1'b0;
            o_rsp_resp   <= '0;
            o_cpl_valid  <= 1'b0;
            o_cpl_id     <= '0;
            o_cpl_resp   <= '0;
            o_cpl_beats  <= '0;
            o_cpl_lenerr <= 1'b0;
            o_stray      <= 1'b0;
        end else begin
            o_cpl_valid <= 1'b0;
            o_stray     <= 1'b0;
            if (beat) begin
                o_rsp_valid <= 1'b1;
                o_rsp_id    <= i_m_rid;
                o_rsp_data  <= i_m_rdata;
                o_rsp_last  <= i_m_rlast;
                o_rsp_resp  <= i_m_rresp;
                if (!rid_busy) begin
                    o_stray <= 1'b1;
                end else if (i_m_rlast) begin
                    o_cpl_valid  <= 1'b1;
                    o_cpl_id     <= i_m_rid;
                    o_cpl_resp   <= new_worst;
                    o_cpl_beats  <= new_cnt;
                    o_cpl_lenerr <= (cur_cnt != {1'b0, cur_exp});
                end
            end else if (i_rsp_ready) begin
                o_rsp_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi4_m_rd_mo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi4_m_rd_mo: directed vector bench for the multi-outstanding read master |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi4_m_rd_mo;

    localparam int TAGW = 3;
    localparam int ADRW = 32;
    localparam int DATW = 256;

    logic            clk = 1'b0;
    logic            i_rst_n;
    logic [ADRW-1:0] req_addr;
    logic [7:0]      req_len;
    logic [2:0]      req_size;
    logic            req_valid, req_ready;
    logic [TAGW-1:0] o_m_arid;
    logic [ADRW-1:0] o_m_araddr;
    logic [7:0]      o_m_arlen;
    logic [2:0]      o_m_arsize;
    logic [1:0]      o_m_arburst;
    logic            o_m_arlock;
    logic [3:0]      o_m_arcache;
    logic [2:0]      o_m_arprot;
    logic [3:0]      o_m_arregion;
    logic            o_m_arvalid, i_m_arready;
    logic [TAGW-1:0] i_m_rid;
    logic [DATW-1:0] i_m_rdata;
    logic [1:0]      i_m_rresp;
    logic            i_m_rlast, i_m_rvalid, o_m_rready;
    logic [TAGW-1:0] o_rsp_id;
    logic [DATW-1:0] o_rsp_data;
    logic            o_rsp_last;
    logic [1:0]      o_rsp_resp;
    logic            o_rsp_valid, i_rsp_ready;
    logic            o_cpl_valid;
    logic [TAGW-1:0] o_cpl_id;
    logic [1:0]      o_cpl_resp;
    logic [8:0]      o_cpl_beats;
    logic            o_cpl_lenerr, o_stray;

    always #5 clk = ~clk;

    axi4_m_rd_mo #(.TAGW(TAGW), .ADRW(ADRW), .DATW(DATW), .MAXO(4), .QDEP(4)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .req_valid(req_valid), .req_ready(req_ready),
        .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr), .o_m_arlen(o_m_arlen),
        .o_m_arsize(o_m_arsize), .o_m_arburst(o_m_arburst), .o_m_arlock(o_m_arlock),
        .o_m_arcache(o_m_arcache), .o_m_arprot(o_m_arprot), .o_m_arregion(o_m_arregion),
        .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready),
        .i_m_rid(i_m_rid), .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp),
        .i_m_rlast(i_m_rlast), .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready),
        .o_rsp_id(o_rsp_id), .o_rsp_data(o_rsp_data), .o_rsp_last(o_rsp_last),
        .o_rsp_resp(o_rsp_resp), .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_cpl_valid(o_cpl_valid), .o_cpl_id(o_cpl_id), .o_cpl_resp(o_cpl_resp),
        .o_cpl_beats(o_cpl_beats), .o_cpl_lenerr(o_cpl_lenerr), .o_stray(o_stray)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [TAGW-1:0] ar_log[$];
    always @(negedge clk) begin
        if (i_rst_n && o_m_arvalid && i_m_arready) ar_log.push_back(o_m_arid);
    end

    typedef struct {
        logic        rv;
        logic [2:0]  rid;
        logic        last;
        logic [15:0] d;
        logic        rdy;
        logic        e_rready;
        logic        e_vld;
        logic [2:0]  e_id;
        logic [15:0] e_d;
        logic        e_cpl;
        logic [2:0]  e_cid;
        logic [8:0]  e_beats;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        logic acc;
        logic done;
        done = 1'b0;
        req_addr = a; req_len = l; req_size = s; req_valid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            #1 acc = req_ready;
            @(posedge clk);
            #1;
            done = acc;
        end
        req_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL req_timeout: got no accept expected accept addr %0h", a);
        end
    endtask

    task automatic beat(input logic [2:0] id, input logic [255:0] d, input logic [1:0] r,
                        input logic last);
        logic acc;
        logic done;
        done = 1'b0;
        i_m_rid = id; i_m_rdata = d; i_m_rresp = r; i_m_rlast = last; i_m_rvalid = 1'b1;
        for (int t = 0; t < 20 && !done; t++) begin
            #1 acc = o_m_rready;
            @(posedge clk);
            #1;
            done = acc;
        end
        i_m_rvalid = 1'b0;
        i_m_rlast  = 1'b0;
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL beat_timeout: got no rready expected rready id %0d", id);
        end
    endtask

    task automatic check_reset();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rready", o_m_rready, 1);
        chk("rst_arvalid", o_m_arvalid, 0);
        chk("rst_arid", o_m_arid, 0);
        chk("rst_araddr", o_m_araddr, 0);
        chk("rst_arlen", o_m_arlen, 0);
        chk("rst_arsize", o_m_arsize, 0);
        chk("rst_arburst", o_m_arburst, 1);
        chk("rst_arlock", o_m_arlock, 0);
        chk("rst_arcache", o_m_arcache, 3);
        chk("rst_arprot", o_m_arprot, 0);
        chk("rst_arregion", o_m_arregion, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_id", o_rsp_id, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        chk("rst_rsp_last", o_rsp_last, 0);
        chk("rst_rsp_resp", o_rsp_resp, 0);
        chk("rst_cpl_valid", o_cpl_valid, 0);
        chk("rst_cpl_id", o_cpl_id, 0);
        chk("rst_cpl_resp", o_cpl_resp, 0);
        chk("rst_cpl_beats", o_cpl_beats, 0);
        chk("rst_cpl_lenerr", o_cpl_lenerr, 0);
        chk("rst_stray", o_stray, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] d;

        // ID0 len=1 (2 beats) interleaved with ID1 len=2 (3 beats) under rsp backpressure.
        tbl[0] = '{1'b1, 3'd0, 1'b0, 16'h0010, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0010, 1'b0, 3'd0, 9'd0};
        tbl[1] = '{1'b1, 3'd1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0010, 1'b0, 3'd0, 9'd0};
        tbl[2] = '{1'b1, 3'd1, 1'b0, 16'h0020, 1'b1, 1'b1, 1'b1, 3'd1, 16'h0020, 1'b0, 3'd0, 9'd0};
        tbl[3] = '{1'b1, 3'd0, 1'b1, 16'h0011, 1'b1, 1'b1, 1'b1, 3'd0, 16'h0011, 1'b1, 3'd0, 9'd2};
        tbl[4] = '{1'b1, 3'd1, 1'b0, 16'h0021, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0011, 1'b0, 3'd0, 9'd0};
        tbl[5] = '{1'b1, 3'd1, 1'b0, 16'h0021, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0011, 1'b0, 3'd0, 9'd0};
        tbl[6] = '{1'b1, 3'd1, 1'b0, 16'h0021, 1'b1, 1'b1, 1'b1, 3'd1, 16'h0021, 1'b0, 3'd0, 9'd0};
        tbl[7] = '{1'b1, 3'd1, 1'b1, 16'h0022, 1'b1, 1'b1, 1'b1, 3'd1, 16'h0022, 1'b1, 3'd1, 9'd3};
        tbl[8] = '{1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 9'd0};

        i_rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
        i_m_arready = 1'b1; i_m_rvalid = 1'b0; i_m_rid = '0; i_m_rdata = '0;
        i_m_rresp = '0; i_m_rlast = 1'b0; i_rsp_ready = 1'b1;
        tick(); tick(); tick();
        check_reset();
        i_rst_n = 1'b1;
        tick();

        // Single read
        push_req(32'h1000, 8'd3, 3'd5);
        chk("sr_arvalid", o_m_arvalid, 1);
        chk("sr_arid", o_m_arid, 0);
        chk("sr_araddr", o_m_araddr, 32'h1000);
        chk("sr_arlen", o_m_arlen, 3);
        chk("sr_arsize", o_m_arsize, 5);
        tick();
        chk("sr_arvalid_drop", o_m_arvalid, 0);
        for (int k = 0; k < 4; k++) begin
            d = {8{32'hA000_0000 + 32'(k)}};
            beat(3'd0, d, 2'b00, k == 3);
            chk("sr_rsp_valid", o_rsp_valid, 1);
            chk("sr_rsp_data", o_rsp_data, d);
            chk("sr_rsp_last", o_rsp_last, k == 3);
            chk("sr_cpl_valid", o_cpl_valid, k == 3);
        end
        chk("sr_cpl_id", o_cpl_id, 0);
        chk("sr_cpl_beats", o_cpl_beats, 4);
        chk("sr_cpl_resp", o_cpl_resp, 0);
        chk("sr_cpl_lenerr", o_cpl_lenerr, 0);
        tick();
        chk("sr_cpl_pulse", o_cpl_valid, 0);
        chk("sr_rsp_drain", o_rsp_valid, 0);

        // Interleave and backpressure, back-to-back AR
        push_req(32'h1100, 8'd1, 3'd5);
        push_req(32'h1200, 8'd2, 3'd5);
        chk("il_arvalid", o_m_arvalid, 1);
        chk("il_arid", o_m_arid, 1);
        chk("il_araddr", o_m_araddr, 32'h1200);
        tick();
        for (int k = 0; k < 9; k++) begin
            i_m_rvalid = tbl[k].rv; i_m_rid = tbl[k].rid; i_m_rlast = tbl[k].last;
            i_m_rdata = {16{tbl[k].d}}; i_m_rresp = 2'b00; i_rsp_ready = tbl[k].rdy;
            #1 chk($sformatf("il_rready[%0d]", k), o_m_rready, tbl[k].e_rready);
            @(posedge clk);
            #1;
            chk($sformatf("il_vld[%0d]", k), o_rsp_valid, tbl[k].e_vld);
            if (tbl[k].e_vld) begin
                chk($sformatf("il_id[%0d]", k), o_rsp_id, tbl[k].e_id);
                chk($sformatf("il_data[%0d]", k), o_rsp_data, {16{tbl[k].e_d}});
            end
            chk($sformatf("il_cpl[%0d]", k), o_cpl_valid, tbl[k].e_cpl);
            if (tbl[k].e_cpl) begin
                chk($sformatf("il_cid[%0d]", k), o_cpl_id, tbl[k].e_cid);
                chk($sformatf("il_beats[%0d]", k), o_cpl_beats, tbl[k].e_beats);
                chk($sformatf("il_lenerr[%0d]", k), o_cpl_lenerr, 0);
            end
        end
        i_m_rvalid = 1'b0; i_m_rlast = 1'b0; i_rsp_ready = 1'b1;

        // Error response then early rlast
        push_req(32'h2000, 8'd1, 3'd5);
        chk("er_arid", o_m_arid, 0);
        tick();
        beat(3'd0, {8{32'h0000_E001}}, 2'b10, 1'b0);
        chk("er_rsp_resp", o_rsp_resp, 2);
        beat(3'd0, {8{32'h0000_E002}}, 2'b00, 1'b1);
        chk("er_cpl_valid", o_cpl_valid, 1);
        chk("er_cpl_resp", o_cpl_resp, 2);
        chk("er_cpl_beats", o_cpl_beats, 2);
        chk("er_cpl_lenerr", o_cpl_lenerr, 0);
        push_req(32'h3000, 8'd3, 3'd5);
        chk("el_arid", o_m_arid, 0);
        tick();
        beat(3'd0, {8{32'h0000_E003}}, 2'b00, 1'b0);
        beat(3'd0, {8{32'h0000_E004}}, 2'b01, 1'b1);
        chk("el_cpl_valid", o_cpl_valid, 1);
        chk("el_cpl_beats", o_cpl_beats, 2);
        chk("el_cpl_lenerr", o_cpl_lenerr, 1);
        chk("el_cpl_resp", o_cpl_resp, 0);

        // Stray beat
        beat(3'd5, {8{32'h0000_5555}}, 2'b00, 1'b1);
        chk("st_stray", o_stray, 1);
        chk("st_rsp_valid", o_rsp_valid, 1);
        chk("st_rsp_id", o_rsp_id, 5);
        chk("st_cpl_valid", o_cpl_valid, 0);
        tick();
        chk("st_stray_pulse", o_stray, 0);

        // Missing rlast: counter saturates at 256
        push_req(32'h4000, 8'd0, 3'd5);
        tick();
        for (int k = 0; k < 300; k++) begin
            beat(3'd0, 256'(k), 2'b00, 1'b0);
            if (k == 0) chk("sat_no_cpl", o_cpl_valid, 0);
        end
        beat(3'd0, 256'd300, 2'b00, 1'b1);
        chk("sat_cpl_valid", o_cpl_valid, 1);
        chk("sat_cpl_beats", o_cpl_beats, 256);
        chk("sat_cpl_lenerr", o_cpl_lenerr, 1);

        // Outstanding limit, queue full, ID reuse
        ar_log.delete();
        for (int k = 0; k < 6; k++) push_req(32'h5000 + 32'(k * 256), 8'd0, 3'd5);
        tick(); tick(); tick();
        chk("lim_stall", o_m_arvalid, 0);
        chk("lim_ar_count", ar_log.size(), 4);
        for (int k = 0; k < ar_log.size(); k++) chk($sformatf("lim_ar_id[%0d]", k), ar_log[k], k);
        chk("lim_req_ready_room", req_ready, 1);
        push_req(32'h5600, 8'd0, 3'd5);
        push_req(32'h5700, 8'd0, 3'd5);
        chk("lim_queue_full", req_ready, 0);
        beat(3'd2, {8{32'h0000_0B02}}, 2'b00, 1'b1);
        chk("reuse_cpl_valid", o_cpl_valid, 1);
        chk("reuse_cpl_id", o_cpl_id, 2);
        chk("reuse_arvalid_lo", o_m_arvalid, 0);
        tick();
        chk("reuse_arvalid", o_m_arvalid, 1);
        chk("reuse_arid", o_m_arid, 2);
        chk("reuse_araddr", o_m_araddr, 32'h5400);
        tick();
        chk("reuse_stall", o_m_arvalid, 0);
        chk("reuse_req_ready", req_ready, 1);
        beat(3'd3, {8{32'h0000_0B03}}, 2'b00, 1'b1);
        tick();
        chk("reuse3_arid", o_m_arid, 3);
        chk("reuse3_araddr", o_m_araddr, 32'h5500);
        tick();
        i_m_arready = 1'b0;
        beat(3'd0, {8{32'h0000_0B00}}, 2'b00, 1'b1);
        tick();
        chk("hold_arvalid", o_m_arvalid, 1);
        chk("hold_arid", o_m_arid, 0);
        tick();
        chk("hold_araddr", o_m_araddr, 32'h5600);

        // Reset with IDs 1..3 outstanding, two queued requests and a pending AR
        i_rst_n = 1'b0;
        tick(); tick();
        check_reset();
        i_rst_n = 1'b1;
        i_m_arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("post_rst_queue_empty", o_m_arvalid, 0);
        end
        beat(3'd1, {8{32'h0000_0DEA}}, 2'b00, 1'b1);
        chk("stale_stray", o_stray, 1);
        chk("stale_no_cpl", o_cpl_valid, 0);
        chk("stale_rsp_id", o_rsp_id, 1);
        push_req(32'h6000, 8'd0, 3'd5);
        chk("post_rst_arvalid", o_m_arvalid, 1);
        chk("post_rst_arid", o_m_arid, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
